// File: rtl/ise_pixel_streamer_pkg.sv
// Shared definitions for the ISE pixel streamer: default geometry, pixel word
// layout and FSM state encoding.
package ise_pkg;

    localparam int DEF_IMAGE_NUM  = 32;
    localparam int DEF_IMAGE_SIZE = 128;
    localparam int DEF_ADDR_W     = 19;
    localparam int TOTAL_PIX      = DEF_IMAGE_NUM * DEF_IMAGE_SIZE * DEF_IMAGE_SIZE;

    localparam int IDX_MSB = 28;
    localparam int IDX_LSB = 24;
    localparam int IDX_W   = IDX_MSB - IDX_LSB + 1;
    localparam int RGB_W   = 24;
    localparam int WORD_W  = IDX_W + RGB_W;

    typedef logic [WORD_W-1:0] pix_word_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

endpackage

// File: rtl/ise_pixel_streamer_if.sv
// Memory read port plus ISE pixel port. master = streamer, slave = memory/ISE side.
interface ise_pixel_streamer_if #(
    parameter int ADDR_W = ise_pkg::DEF_ADDR_W
);
    logic                      mem_ren;
    logic [ADDR_W-1:0]         mem_addr;
    logic [ise_pkg::WORD_W-1:0] mem_rdata;
    logic                      busy;
    logic                      pix_valid;
    logic [ise_pkg::IDX_W-1:0] image_in_index;
    logic [ise_pkg::RGB_W-1:0] pixel_in;

    modport master (
        output mem_ren, mem_addr, pix_valid, image_in_index, pixel_in,
        input  mem_rdata, busy
    );

    modport slave (
        input  mem_ren, mem_addr, pix_valid, image_in_index, pixel_in,
        output mem_rdata, busy
    );
endinterface

// File: rtl/ise_pixel_streamer_skid_fifo.sv
// Two-entry synchronous FIFO behind the streamer output register.
// Push and pop in the same cycle are legal, including when full.
module ise_skid_fifo
    import ise_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  pix_word_t wdata,
    output pix_word_t rdata,
    output logic [1:0] cnt
);

    pix_word_t  mem_q [2];
    pix_word_t  mem_d [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] cnt_q, cnt_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        cnt_d    = cnt_q + 2'(push) - 2'(pop);
        // When full, wr_ptr == rd_ptr: the head is read out this cycle before
        // the overwrite lands at the edge.
        if (push) mem_d[wr_ptr_q] = wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign cnt   = cnt_q;

endmodule

// File: rtl/ise_pixel_streamer.sv
// Streams pixel memory linearly into the ISE pixel port at up to one word per
// cycle, hiding the one-cycle memory latency with a 2-entry skid FIFO.
module ise_pixel_streamer
    import ise_pkg::*;
#(
    parameter int IMAGE_NUM  = DEF_IMAGE_NUM,
    parameter int IMAGE_SIZE = DEF_IMAGE_SIZE,
    parameter int ADDR_W     = DEF_ADDR_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    ise_pixel_streamer_if.master bus,
    output logic                 done,
    output logic                 idx_err
);

    localparam int              IMG_PIX = IMAGE_SIZE * IMAGE_SIZE;
    localparam int              TOTAL   = IMAGE_NUM * IMG_PIX;
    localparam logic [ADDR_W:0] TOTAL_C = (ADDR_W+1)'(TOTAL);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   rd_cnt_q, rd_cnt_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic              pix_valid_q, pix_valid_d;
    pix_word_t         word_q, word_d;
    logic              done_q, done_d;
    logic              idx_err_q, idx_err_d;

    logic              ren, consume, load, push, pop;
    logic [1:0]        fifo_cnt;
    logic [2:0]        fifo_cnt_next;
    pix_word_t         fifo_head;
    logic [IDX_W-1:0]  exp_idx;

    ise_skid_fifo u_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (push),
        .pop   (pop),
        .wdata (bus.mem_rdata),
        .rdata (fifo_head),
        .cnt   (fifo_cnt)
    );

    // Image index implied by the address of the word returning this cycle.
    assign exp_idx = IDX_W'(32'(raddr_q) / 32'(IMG_PIX));

    always_comb begin
        state_d     = state_q;
        rd_cnt_d    = rd_cnt_q;
        pix_valid_d = pix_valid_q;
        word_d      = word_q;
        done_d      = 1'b0;
        idx_err_d   = idx_err_q;
        pop         = 1'b0;
        ren         = 1'b0;

        consume = pix_valid_q && !bus.busy;
        load    = !pix_valid_q || consume;

        if (load) begin
            if (fifo_cnt != 2'd0) begin
                pop         = 1'b1;
                pix_valid_d = 1'b1;
                word_d      = fifo_head;
            end else if (inflight_q) begin
                pix_valid_d = 1'b1;
                word_d      = bus.mem_rdata;
            end else begin
                pix_valid_d = 1'b0;
                word_d      = '0;
            end
        end

        // Returning data is never dropped: it either bypasses or is queued.
        push          = inflight_q && !(load && fifo_cnt == 2'd0);
        fifo_cnt_next = 3'(fifo_cnt) + 3'(push) - 3'(pop);

        if (inflight_q && bus.mem_rdata[IDX_MSB:IDX_LSB] != exp_idx)
            idx_err_d = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_STREAM;
                    rd_cnt_d = '0;
                end
            end
            ST_STREAM: begin
                ren = (rd_cnt_q < TOTAL_C) && ((fifo_cnt_next + 3'(inflight_q)) < 3'd2);
                if (ren) rd_cnt_d = rd_cnt_q + (ADDR_W+1)'(1);
                if (rd_cnt_q == TOTAL_C) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (!inflight_q && fifo_cnt == 2'd0 && load) begin
                    state_d  = ST_IDLE;
                    done_d   = 1'b1;
                    rd_cnt_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        inflight_d = ren;
        raddr_d    = ren ? rd_cnt_q[ADDR_W-1:0] : raddr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rd_cnt_q    <= '0;
            inflight_q  <= 1'b0;
            raddr_q     <= '0;
            pix_valid_q <= 1'b0;
            word_q      <= '0;
            done_q      <= 1'b0;
            idx_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_cnt_q    <= rd_cnt_d;
            inflight_q  <= inflight_d;
            raddr_q     <= raddr_d;
            pix_valid_q <= pix_valid_d;
            word_q      <= word_d;
            done_q      <= done_d;
            idx_err_q   <= idx_err_d;
        end
    end

    assign bus.mem_ren        = ren;
    assign bus.mem_addr       = rd_cnt_q[ADDR_W-1:0];
    assign bus.pix_valid      = pix_valid_q;
    assign bus.image_in_index = word_q[IDX_MSB:IDX_LSB];
    assign bus.pixel_in       = word_q[RGB_W-1:0];
    assign done               = done_q;
    assign idx_err            = idx_err_q;

endmodule

// File: tb/tb_ise_pixel_streamer.sv
// Scoreboard bench for ise_pixel_streamer on a reduced geometry (4 images of 8x8).
module tb_ise_pixel_streamer;
    import ise_pkg::*;

    localparam int IN   = 4;
    localparam int IS   = 8;
    localparam int AW   = 8;
    localparam int IMGP = IS * IS;
    localparam int TOT  = IN * IMGP;
    localparam int M_FREE = 0, M_BP = 1, M_END = 2, M_IDX = 3, M_RST = 4;

    logic clk = 1'b0, reset = 1'b0, start = 1'b0;
    logic done, idx_err;
    always #5 clk = ~clk;

    ise_pixel_streamer_if #(.ADDR_W(AW)) bus ();

    ise_pixel_streamer #(.IMAGE_NUM(IN), .IMAGE_SIZE(IS), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .bus(bus), .done(done), .idx_err(idx_err)
    );

    pix_word_t mem [TOT];
    pix_word_t exp_q [$];
    int n_tests = 0, n_fail = 0, cyc = 0;
    int ncons, gaps, ndone, last_cons, done_cyc;
    logic prev_hold = 1'b0;
    pix_word_t prev_word = '0;
    bit fin;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_ren) bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic pix_word_t mk_word(input int a);
        return {5'(a / IMGP), 24'((a * 32'h010203) ^ 32'hA5A5A5)};
    endfunction

    // Monitor: a word is consumed at the next rising edge when valid && !busy.
    always @(negedge clk) begin
        if (reset) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold)
                chk("hold_stable", 64'({bus.pix_valid, bus.image_in_index, bus.pixel_in}),
                    64'({1'b1, prev_word}));
            chk("fifo_le2", 64'(dut.u_fifo.cnt_q <= 2'd2), 64'(1));
            if (done) begin ndone++; done_cyc = cyc; end
            if (bus.pix_valid && !bus.busy) begin
                chk("sb_nonempty", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0)
                    chk("pix_word", 64'({bus.image_in_index, bus.pixel_in}), 64'(exp_q.pop_front()));
                if (ncons > 0 && cyc != last_cons + 1) gaps++;
                last_cons = cyc;
                ncons++;
            end
            prev_hold = bus.pix_valid && bus.busy;
            prev_word = {bus.image_in_index, bus.pixel_in};
        end
    end

    task automatic load_mem(input bit corrupt);
        exp_q.delete();
        for (int a = 0; a < TOT; a++) mem[a] = mk_word(a);
        if (corrupt) mem[IMGP][28:24] = 5'd3;
        for (int a = 0; a < TOT; a++) exp_q.push_back(mem[a]);
    endtask

    task automatic clear_stats();
        ncons = 0; gaps = 0; ndone = 0; last_cons = -10; done_cyc = -1;
    endtask

    task automatic kick();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic stream(input int mode, input int max_cyc, output bit fin_o);
        int c = 0, burst = 0, r = -1, endbp = 0;
        bit fl = 0;
        fin_o = 0;
        while (!fin_o && c < max_cyc) begin
            @(posedge clk); #1; c++;
            start = 1'b0;
            if (done) fin_o = 1;
            if (mode == M_FREE && c == 1) chk("lat_e1_invalid", 64'(bus.pix_valid), 64'(0));
            if (mode == M_FREE && c == 2) begin
                chk("lat_e2_valid", 64'(bus.pix_valid), 64'(1));
                chk("first_word", 64'({bus.image_in_index, bus.pixel_in}), 64'(mk_word(0)));
            end
            case (mode)
                M_BP: begin
                    if (ncons >= 100 && burst < 5) begin bus.busy = 1'b1; burst++; end
                    else if (ncons >= 100) bus.busy = 1'($urandom_range(0, 1));
                    else bus.busy = 1'b0;
                    if (c == 20) start = 1'b1;
                    if (dut.state_q == ST_FLUSH && !fl) begin start = 1'b1; fl = 1; end
                end
                M_END: begin
                    if (ncons == TOT - 1 && bus.pix_valid && endbp < 10) begin
                        bus.busy = 1'b1; endbp++;
                    end else bus.busy = 1'b0;
                end
                M_IDX: begin
                    bus.busy = 1'b0;
                    if (r >= 0 && c == r + 1) chk("idx_err_early", 64'(idx_err), 64'(0));
                    if (r >= 0 && c == r + 2) chk("idx_err_rise", 64'(idx_err), 64'(1));
                    if (bus.mem_ren && bus.mem_addr == AW'(IMGP) && r < 0) r = c;
                end
                M_RST: begin
                    bus.busy = 1'b0;
                    if (ncons >= 100) break;
                end
                default: bus.busy = 1'b0;
            endcase
        end
        if (mode == M_BP)  chk("flush_start_seen", 64'(fl), 64'(1));
        if (mode == M_END) chk("end_hold_cycles", 64'(endbp), 64'(10));
        bus.busy = 1'b0;
    endtask

    task automatic post_checks();
        chk("done_seen", 64'(fin), 64'(1));
        @(posedge clk); #1;
        chk("done_pulse_1cyc", 64'(done), 64'(0));
        chk("pix_count", 64'(ncons), 64'(TOT));
        chk("sb_drained", 64'(exp_q.size()), 64'(0));
        chk("done_count", 64'(ndone), 64'(1));
        chk("done_latency", 64'(done_cyc), 64'(last_cons + 1));
        chk("idle_no_ren", 64'(bus.mem_ren), 64'(0));
    endtask

    initial begin
        bus.busy = 1'b0;
        #1 reset = 1'b1;
        #2;
        chk("rst_pix_valid", 64'(bus.pix_valid), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_idx_err", 64'(idx_err), 64'(0));
        chk("rst_mem_ren", 64'(bus.mem_ren), 64'(0));
        chk("rst_index", 64'(bus.image_in_index), 64'(0));
        chk("rst_pixel", 64'(bus.pixel_in), 64'(0));
        @(negedge clk) reset = 1'b0;

        // free run: full rate, no gaps
        load_mem(0); clear_stats(); kick();
        chk("lat_ren", 64'(bus.mem_ren), 64'(1));
        chk("lat_addr0", 64'(bus.mem_addr), 64'(0));
        stream(M_FREE, TOT + 50, fin);
        post_checks();
        chk("free_no_gaps", 64'(gaps), 64'(0));
        chk("free_idx_err", 64'(idx_err), 64'(0));

        // back-pressure with stray start pulses in STREAM and FLUSH
        load_mem(0); clear_stats(); kick();
        stream(M_BP, 4000, fin);
        post_checks();
        repeat (5) @(posedge clk);
        #1;
        chk("no_restart_done", 64'(ndone), 64'(1));
        chk("no_restart_valid", 64'(bus.pix_valid), 64'(0));

        // busy held over the final pixel
        load_mem(0); clear_stats(); kick();
        stream(M_END, TOT + 100, fin);
        post_checks();

        // corrupted index word
        chk("idx_err_clean", 64'(idx_err), 64'(0));
        load_mem(1); clear_stats(); kick();
        stream(M_IDX, TOT + 50, fin);
        post_checks();
        chk("idx_err_sticky", 64'(idx_err), 64'(1));

        // reset mid-stream, then a fresh stream from address 0
        load_mem(0); clear_stats(); kick();
        stream(M_RST, TOT + 50, fin);
        #1 reset = 1'b1;
        #1;
        chk("mrst_pix_valid", 64'(bus.pix_valid), 64'(0));
        chk("mrst_mem_ren", 64'(bus.mem_ren), 64'(0));
        chk("mrst_index", 64'(bus.image_in_index), 64'(0));
        chk("mrst_pixel", 64'(bus.pixel_in), 64'(0));
        chk("mrst_idx_err", 64'(idx_err), 64'(0));
        chk("mrst_done", 64'(done), 64'(0));
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("mrst_no_done", 64'(ndone), 64'(0));

        load_mem(0); clear_stats(); kick();
        chk("restart_ren", 64'(bus.mem_ren), 64'(1));
        chk("restart_addr0", 64'(bus.mem_addr), 64'(0));
        stream(M_FREE, TOT + 50, fin);
        post_checks();
        chk("restart_no_gaps", 64'(gaps), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ise_pixel_streamer.md
Name: ise_pixel_streamer

Overview:
- Feeds the Image Sorting Engine input port from a pixel memory. Walks the memory linearly and presents one {image_in_index, pixel_in} word per transfer, honouring ISE's busy back-pressure.
- Transmit end of the ISE pixel interface; replaces the behavioural pixel driver used in simulation.
- Sustains 1 pixel/cycle while busy stays low, despite the 1-cycle memory read latency.

Parameters:
- IMAGE_NUM, 32, number of images in the stream
- IMAGE_SIZE, 128, image edge length in pixels
- ADDR_W, 19, memory address width (log2 of IMAGE_NUM*IMAGE_SIZE*IMAGE_SIZE)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse: begin streaming; ignored unless in IDLE
- mem_ren  out  1  memory read enable
- mem_addr  out  ADDR_W  memory read address
- mem_rdata  in  29  memory word, {[28:24] image index, [23:0] RGB}; valid the cycle after mem_ren
- busy  in  1  ISE back-pressure
- pix_valid  out  1  output word is valid
- image_in_index  out  5  image index of the current pixel
- pixel_in  out  24  RGB pixel
- done  out  1  one-cycle pulse after the last pixel is consumed
- idx_err  out  1  sticky: a memory word's index did not match its address

Behaviour:
- Reset (asynchronous): state IDLE; pix_valid, done, idx_err, mem_ren, image_in_index, pixel_in all 0; counters and FIFO cleared. Reset mid-stream abandons the stream; no done pulse.
- TOTAL = IMAGE_NUM*IMAGE_SIZE*IMAGE_SIZE. rd_cnt (ADDR_W+1 bits) counts reads issued; mem_addr = rd_cnt[ADDR_W-1:0].
- Transfer: a pixel is consumed at a rising edge where pix_valid=1 and busy=0. While busy=1, the output registers hold their value unchanged.
- Output register load: load from the FIFO head, or directly from mem_rdata when the FIFO is empty (bypass), whenever pix_valid=0 or the current word is consumed. If nothing is available, pix_valid goes to 0 and image_in_index/pixel_in go to 0.
- Buffering: a 2-entry FIFO sits behind the output register. Memory data returning in a cycle is always accepted (bypass or FIFO write).
- Read issue (combinational, STREAM only): mem_ren = (rd_cnt < TOTAL) && (fifo_cnt_next + inflight < 2). fifo_cnt_next accounts for this cycle's pop and bypass. inflight = mem_ren registered.
- FSM states:
  - IDLE: on start -> STREAM.
  - STREAM: issue reads; when rd_cnt == TOTAL -> FLUSH.
  - FLUSH: no reads. When inflight=0, FIFO empty and the last word is consumed -> IDLE, with done=1 for exactly one cycle.
- Latency: start sampled at edge E0 -> mem_ren=1 with addr 0 in the following cycle -> pix_valid=1 after edge E2.
- Throughput: with busy tied low, TOTAL pixels are consumed in TOTAL consecutive cycles.
- Index check: every returned word is compared with expected index = address / (IMAGE_SIZE*IMAGE_SIZE), i.e. address[ADDR_W-1:14] at default parameters. A mismatch sets idx_err until reset. Streaming continues and the word is forwarded unchanged.
- start in STREAM or FLUSH: ignored.
- Busy asserted on the very cycle the last pixel is presented: hold it; done follows its consumption.

Decomposition:
- Shared ise_pkg: IMAGE_NUM, IMAGE_SIZE, TOTAL_PIX, pixel word field positions (IDX_MSB=28, IDX_LSB=24, RGB width 24), FSM state encoding.
- One sub-module: ise_skid_fifo, a 2-entry synchronous FIFO (29-bit data; push/pop/cnt; simultaneous push+pop allowed when full).

Test Plan:
- Free run: busy=0, memory word at addr a = {a>>14, a[23:0] pattern} -> 524288 pixels in order on 524288 consecutive cycles; first valid 2 edges after start; one done pulse; idx_err=0.
- Back-pressure: busy=1 for 5 cycles at pixel 100, then random 50% busy -> no pixel dropped or duplicated; held word stable while busy; FIFO never exceeds 2.
- Index error: corrupt addr 16384 to index 5'd3 -> idx_err rises the cycle after its read returns and stays 1; word forwarded as-is; stream completes.
- Start ignored: second start pulse during STREAM and FLUSH -> no restart; rd_cnt unaffected; single done.
- Reset mid-stream: reset at pixel 1000 -> all outputs 0 immediately (asynchronous); no done; a new start streams again from addr 0.
- End back-pressure: busy=1 from presentation of the final pixel for 10 cycles -> pixel held, done pulses exactly one cycle after the consuming edge; FSM returns to IDLE.
